mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequences the single shared main memory between I-cache block fills, D-cache block fills
//  and D-cache write-through stores of the 16-bit pipelined CPU.
//  Picks one requester and streams block-fill read addresses into the pipelined memory.
//  Steers returned words to the winning cache and raises stalls for the IF and MEM stages.
//  Sits between both caches and the memory; the EX/MEM datapath sees it only via stall_mem.
// PARAMETERS
//  WORD_IDX_W   3   log2(words per block); BLOCK_WORDS = 1<<WORD_IDX_W = 8 (16-byte block)
//  MEM_LAT      4   memory read latency, mem_en to mem_data_valid; bench model only, RTL uses valid
// PORTS
//  clk            in   1   clock; all state changes on rising edge
//  rst            in   1   synchronous, active-high reset
//  ic_miss        in   1   I-cache miss; held until ic_fill_done
//  ic_miss_addr   in   16  byte address of I-cache miss
//  dc_miss        in   1   D-cache miss; held until dc_fill_done
//  dc_miss_addr   in   16  byte address of D-cache miss
//  dc_wr_req      in   1   write-through store; held until dc_wr_done
//  dc_wr_addr     in   16  store byte address
//  dc_wr_data     in   16  store data
//  mem_data_out   in   16  read data from memory
//  mem_data_valid in   1   mem_data_out valid this cycle
//  mem_en         out  1   memory access strobe, one access per cycle
//  mem_wr         out  1   1 = write, 0 = read (meaningful only with mem_en)
//  mem_addr       out  16  memory byte address
//  mem_data_in    out  16  memory write data
//  fill_data      out  16  word being filled (= mem_data_out)
//  fill_word      out  3   word index within block
//  ic_fill_we     out  1   write fill_data into I-cache line
//  dc_fill_we     out  1   write fill_data into D-cache line
//  ic_fill_done   out  1   one-cycle pulse, last I-cache word written
//  dc_fill_done   out  1   one-cycle pulse, last D-cache word written
//  dc_wr_done     out  1   one-cycle pulse, store issued to memory
//  stall_if       out  1   ic_miss & ~ic_fill_done
//  stall_mem      out  1   (dc_miss & ~dc_fill_done) | (dc_wr_req & ~dc_wr_done)
// BEHAVIOUR
//  Reset: state IDLE; issue/receive counters 0; mem_en, mem_wr, mem_addr, mem_data_in cleared.
//   All *_we and *_done outputs also 0.
//  States: IDLE, WRITE, FILL_DC, FILL_IC. Arbitration only in IDLE; no preemption.
//  IDLE priority: dc_wr_req > dc_miss > ic_miss. Decision at edge T moves state at T+1.
//  WRITE (1 cycle, T+1):
//   - mem_en=1, mem_wr=1; mem_addr/mem_data_in = registered dc_wr_addr/dc_wr_data.
//   - dc_wr_done=1; return to IDLE at T+2.
//  FILL_x:
//   - base = miss_addr & 16'hFFF0, latched on entry.
//   - Issue counter i=0..7: mem_en=1, mem_wr=0, mem_addr = base + 2*i on cycles T+1..T+8; mem_en=0 after.
//   - Each mem_data_valid in FILL_x: fill_data=mem_data_out, fill_word=receive count, x_fill_we=1
//     same cycle (combinational from valid); receive count +1.
//   - 8th valid word: x_fill_done=1 same cycle; IDLE next cycle.
//   - MEM_LAT=4: words T+5..T+12, done T+12.
//  mem_data_valid in IDLE/WRITE ignored: no we, no count.
//  Requester dropping its request mid-fill: fill still completes; done still pulses.
//  ic_miss and dc_miss same cycle: DC fill first. IC fill starts the cycle after dc_fill_done's IDLE cycle.
//  Stall outputs are combinational; they deassert in the done-pulse cycle so the pipeline advances next edge.
//  rst mid-fill: IDLE next cycle, counters 0; in-flight returns ignored. A still-held request re-arbitrates.
//  Address arithmetic 16-bit; base+14 never carries out of block.
// TESTING
//  dc_miss, addr 0x1236, MEM_LAT=4 -> mem_addr 0x1230..0x123E on T+1..T+8;
//   dc_fill_we words 0..7 T+5..T+12; dc_fill_done T+12 only.
//  ic_miss + dc_miss same cycle -> DC fill completes first; IC fill issues 8 reads after;
//   stall_if high throughout until ic_fill_done.
//  dc_wr_req 0x0040/0xBEEF with ic_miss pending -> one WRITE (mem_wr=1, 0x0040, 0xBEEF, dc_wr_done), then IC fill.
//  rst asserted mid DC fill (after 3 words) -> IDLE, no further we/done; later returns ignored.
//   dc_miss held -> fresh full fill.
//  Spurious mem_data_valid in IDLE -> no fill_we, no done; ic_miss dropped mid-fill ->
//   fill still completes with ic_fill_done.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: write-through stores and 8-word I/D-cache block fills.
// Fixed priority, no preemption. Fill returns are steered to the granted cache.
module mem_arbiter #(
  parameter int WORD_IDX_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_miss_i,
  input  logic [15:0]           ic_miss_addr_i,
  input  logic                  dc_miss_i,
  input  logic [15:0]           dc_miss_addr_i,
  input  logic                  dc_wr_req_i,
  input  logic [15:0]           dc_wr_addr_i,
  input  logic [15:0]           dc_wr_data_i,
  input  logic [15:0]           mem_data_out_i,
  input  logic                  mem_data_valid_i,
  output logic                  mem_en_o,
  output logic                  mem_wr_o,
  output logic [15:0]           mem_addr_o,
  output logic [15:0]           mem_data_in_o,
  output logic [15:0]           fill_data_o,
  output logic [WORD_IDX_W-1:0] fill_word_o,
  output logic                  ic_fill_we_o,
  output logic                  dc_fill_we_o,
  output logic                  ic_fill_done_o,
  output logic                  dc_fill_done_o,
  output logic                  dc_wr_done_o,
  output logic                  stall_if_o,
  output logic                  stall_mem_o
);
  localparam logic [15:0] BLK_MASK = ~16'((1 << (WORD_IDX_W + 1)) - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_DC, FILL_IC} state_e;

  state_e                state_q, state_d;
  logic [WORD_IDX_W:0]   iss_q, iss_d;   // MSB set once the whole block has been requested
  logic [WORD_IDX_W-1:0] rcv_q, rcv_d;
  logic [15:0]           base_q, base_d;
  logic [15:0]           wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      iss_q     <= '0;
      rcv_q     <= '0;
      base_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      iss_q     <= iss_d;
      rcv_q     <= rcv_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    iss_d          = iss_q;
    rcv_d          = rcv_q;
    base_d         = base_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    mem_en_o       = 1'b0;
    mem_wr_o       = 1'b0;
    mem_addr_o     = '0;
    mem_data_in_o  = '0;
    ic_fill_we_o   = 1'b0;
    dc_fill_we_o   = 1'b0;
    ic_fill_done_o = 1'b0;
    dc_fill_done_o = 1'b0;
    dc_wr_done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        iss_d = '0;
        rcv_d = '0;
        if (dc_wr_req_i) begin
          state_d   = WRITE;
          wr_addr_d = dc_wr_addr_i;
          wr_data_d = dc_wr_data_i;
        end else if (dc_miss_i) begin
          state_d = FILL_DC;
          base_d  = dc_miss_addr_i & BLK_MASK;
        end else if (ic_miss_i) begin
          state_d = FILL_IC;
          base_d  = ic_miss_addr_i & BLK_MASK;
        end
      end
      WRITE: begin
        mem_en_o      = 1'b1;
        mem_wr_o      = 1'b1;
        mem_addr_o    = wr_addr_q;
        mem_data_in_o = wr_data_q;
        dc_wr_done_o  = 1'b1;
        state_d       = IDLE;
      end
      FILL_DC, FILL_IC: begin
        if (!iss_q[WORD_IDX_W]) begin
          mem_en_o   = 1'b1;
          mem_addr_o = base_q + {{(15-WORD_IDX_W){1'b0}}, iss_q[WORD_IDX_W-1:0], 1'b0};
          iss_d      = iss_q + 1'b1;
        end
        // Returns are counted, not matched to issues; the memory answers in order.
        if (mem_data_valid_i) begin
          rcv_d = rcv_q + 1'b1;
          if (state_q == FILL_DC) dc_fill_we_o = 1'b1;
          else                    ic_fill_we_o = 1'b1;
          if (&rcv_q) begin
            if (state_q == FILL_DC) dc_fill_done_o = 1'b1;
            else                    ic_fill_done_o = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_data_o = mem_data_out_i;
  assign fill_word_o = rcv_q;
  assign stall_if_o  = ic_miss_i & ~ic_fill_done_o;
  assign stall_mem_o = (dc_miss_i & ~dc_fill_done_o) | (dc_wr_req_i & ~dc_wr_done_o);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a latency-MEM_LAT memory, holding requesters and a
// transaction-level model that predicts every cycle from grant start time and block offset.
module tb_mem_arbiter;
  localparam int WORD_IDX_W = 3;
  localparam int BW         = 1 << WORD_IDX_W;
  localparam int MEM_LAT    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_miss, dc_miss, dc_wr_req, mem_data_valid;
  logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data, mem_data_out;
  logic        mem_en, mem_wr, ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_done;
  logic        stall_if, stall_mem;
  logic [15:0] mem_addr, mem_data_in, fill_data;
  logic [WORD_IDX_W-1:0] fill_word;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_IDX_W(WORD_IDX_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_miss_i(ic_miss), .ic_miss_addr_i(ic_miss_addr),
    .dc_miss_i(dc_miss), .dc_miss_addr_i(dc_miss_addr),
    .dc_wr_req_i(dc_wr_req), .dc_wr_addr_i(dc_wr_addr), .dc_wr_data_i(dc_wr_data),
    .mem_data_out_i(mem_data_out), .mem_data_valid_i(mem_data_valid),
    .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_in_o(mem_data_in),
    .fill_data_o(fill_data), .fill_word_o(fill_word),
    .ic_fill_we_o(ic_fill_we), .dc_fill_we_o(dc_fill_we),
    .ic_fill_done_o(ic_fill_done), .dc_fill_done_o(dc_fill_done), .dc_wr_done_o(dc_wr_done),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] rom(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  typedef struct packed { int due; logic [15:0] addr; } rd_t;
  rd_t rdq[$];

  // model: 0 none, 1 store, 2 D fill, 3 I fill; g_start is the first active cycle
  int          cyc = 0;
  int          g_kind = 0;
  int          g_start = 0;
  logic [15:0] g_base, g_waddr, g_wdata;
  bit          wr_busy = 0, dc_busy = 0, ic_busy = 0, ic_drop = 0;
  logic [15:0] wa, wd, dc_a, ic_a;
  int          rst_left = 0;
  bit          rnd_on = 0;

  task automatic step();
    bit          x_en, x_wr, x_icwe, x_dcwe, x_icdn, x_dcdn, x_wrdn;
    logic [15:0] x_addr, x_din, x_fd;
    int          x_word, k;
    if (rnd_on) begin
      if (!wr_busy && $urandom_range(0, 19) == 0) begin wr_busy = 1; wa = 16'($urandom); wd = 16'($urandom); end
      if (!dc_busy && $urandom_range(0, 14) == 0) begin dc_busy = 1; dc_a = 16'($urandom); end
      if (!ic_busy && $urandom_range(0, 9) == 0)  begin ic_busy = 1; ic_drop = 0; ic_a = 16'($urandom); end
      if (ic_busy && !ic_drop && g_kind == 3 && $urandom_range(0, 29) == 0) ic_drop = 1;
      if (rst_left == 0 && g_kind >= 2 && $urandom_range(0, 199) == 0) rst_left = MEM_LAT + 1;
    end
    rst          = (rst_left > 0);
    dc_wr_req    = wr_busy; dc_wr_addr = wa; dc_wr_data = wd;
    dc_miss      = dc_busy; dc_miss_addr = dc_a;
    ic_miss      = ic_busy & ~ic_drop; ic_miss_addr = ic_a;
    mem_data_valid = 1'b0;
    mem_data_out   = 16'($urandom);
    if (rdq.size() > 0 && rdq[0].due <= cyc) begin
      mem_data_valid = 1'b1;
      mem_data_out   = rom(rdq[0].addr);
      while (rdq.size() > 0 && rdq[0].due <= cyc) void'(rdq.pop_front());
    end else if (rdq.size() == 0 && g_kind < 2 && $urandom_range(0, 3) == 0) begin
      mem_data_valid = 1'b1;   // stray return outside a fill
    end

    {x_en, x_wr, x_icwe, x_dcwe, x_icdn, x_dcdn, x_wrdn} = '0;
    x_addr = '0; x_din = '0; x_fd = '0; x_word = 0;
    k = cyc - g_start;
    if (g_kind == 1) begin
      x_en = 1; x_wr = 1; x_addr = g_waddr; x_din = g_wdata; x_wrdn = 1;
    end else if (g_kind >= 2) begin
      if (k < BW) begin x_en = 1; x_addr = g_base + 16'(2 * k); end
      if (k >= MEM_LAT && k < MEM_LAT + BW) begin
        if (g_kind == 2) x_dcwe = 1; else x_icwe = 1;
        x_word = k - MEM_LAT;
        x_fd   = rom(g_base + 16'(2 * x_word));
      end
      if (k == MEM_LAT + BW - 1) begin
        if (g_kind == 2) x_dcdn = 1; else x_icdn = 1;
      end
    end

    #2;
    chk("mem_en", mem_en, x_en);
    if (x_en) begin
      chk("mem_wr", mem_wr, x_wr);
      chk("mem_addr", mem_addr, x_addr);
      if (x_wr) chk("mem_data_in", mem_data_in, x_din);
    end
    chk("ic_fill_we", ic_fill_we, x_icwe);
    chk("dc_fill_we", dc_fill_we, x_dcwe);
    if (x_icwe || x_dcwe) begin
      chk("fill_word", fill_word, 32'(x_word));
      chk("fill_data", fill_data, x_fd);
    end
    chk("ic_fill_done", ic_fill_done, x_icdn);
    chk("dc_fill_done", dc_fill_done, x_dcdn);
    chk("dc_wr_done", dc_wr_done, x_wrdn);
    chk("stall_if", stall_if, ic_miss & ~x_icdn);
    chk("stall_mem", stall_mem, (dc_miss & ~x_dcdn) | (dc_wr_req & ~x_wrdn));

    if (mem_en === 1'b1 && mem_wr === 1'b0) rdq.push_back('{due: cyc + MEM_LAT, addr: mem_addr});

    if (x_wrdn) wr_busy = 0;
    if (x_dcdn) dc_busy = 0;
    if (x_icdn) begin ic_busy = 0; ic_drop = 0; end
    if (rst) begin
      g_kind = 0;
      if (ic_drop) begin ic_busy = 0; ic_drop = 0; end
    end else if (g_kind == 0) begin
      if (dc_wr_req)    begin g_kind = 1; g_start = cyc + 1; g_waddr = wa; g_wdata = wd; end
      else if (dc_miss) begin g_kind = 2; g_start = cyc + 1; g_base = dc_a & 16'hFFF0; end
      else if (ic_miss) begin g_kind = 3; g_start = cyc + 1; g_base = ic_a & 16'hFFF0; end
    end else if (g_kind == 1 || k == MEM_LAT + BW - 1) begin
      g_kind = 0;
    end
    if (rst_left > 0) rst_left--;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1; ic_miss = 0; dc_miss = 0; dc_wr_req = 0; mem_data_valid = 0;
    ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0; mem_data_out = '0;
    wa = '0; wd = '0; dc_a = '0; ic_a = '0;
    repeat (2) @(posedge clk);
    #1;
    mem_data_valid = 1'b1;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_fill_we", {ic_fill_we, dc_fill_we}, 0);
    chk("rst_done", {ic_fill_done, dc_fill_done, dc_wr_done}, 0);
    chk("rst_fill_word", fill_word, 0);
    mem_data_valid = 1'b0;
    @(posedge clk);
    #1;

    // D and I miss together, D block at 0x1236 goes first
    dc_busy = 1; dc_a = 16'h1236; ic_busy = 1; ic_a = 16'h0458;
    for (int i = 0; i < 80 && (dc_busy || ic_busy); i++) step();
    chk("dual_fill_finished", {dc_busy, ic_busy}, 0);

    // store with an I miss pending
    ic_busy = 1; ic_a = 16'h2000; wr_busy = 1; wa = 16'h0040; wd = 16'hBEEF;
    for (int i = 0; i < 60 && (wr_busy || ic_busy); i++) step();
    chk("store_then_fill_finished", {wr_busy, ic_busy}, 0);

    // reset after three D words, request held -> fresh fill
    dc_busy = 1; dc_a = 16'h3008;
    for (int i = 0; i < 40 && !(g_kind == 2 && cyc - g_start == MEM_LAT + 2); i++) step();
    chk("reached_mid_fill", 32'(g_kind == 2 && cyc - g_start == MEM_LAT + 2), 1);
    rst_left = MEM_LAT + 1;
    for (int i = 0; i < 60 && dc_busy; i++) step();
    chk("refill_finished", dc_busy, 0);

    // I miss dropped mid-fill
    ic_busy = 1; ic_drop = 0; ic_a = 16'h5678;
    for (int i = 0; i < 40 && !(g_kind == 3 && cyc - g_start == 2); i++) step();
    ic_drop = 1;
    for (int i = 0; i < 40 && ic_busy; i++) step();
    chk("dropped_fill_finished", ic_busy, 0);

    rnd_on = 1;
    for (int i = 0; i < 4000; i++) step();
    rnd_on = 0;
    for (int i = 0; i < 200 && (wr_busy || dc_busy || ic_busy || g_kind != 0); i++) step();
    chk("drain", {wr_busy, dc_busy, ic_busy, 1'b0} | 32'(g_kind != 0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
